// File: rtl/pixel_write_ctrl_pkg.sv
// Shared constants and FSM encoding for the pixel write controller.
package pixel_write_ctrl_pkg;

  localparam int unsigned H_RES   = 320;
  localparam int unsigned V_RES   = 240;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned COLOR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_write_ctrl_fifo.sv
// pix_fifo: synchronous FIFO with wrapping pointers and an occupancy count.
// Head entry is presented combinationally on rdata.
module pix_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                wdata,
  output logic [DW-1:0]                rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  import pixel_write_ctrl_pkg::*;

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_ctrl.sv
// Buffers line pixels as framebuffer writes and drives a single-outstanding
// write handshake. Optional clipping enabled by macro PIX_CLIP_EN.
module pixel_write_ctrl #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned H_RES  = pixel_write_ctrl_pkg::H_RES,
  parameter int unsigned V_RES  = pixel_write_ctrl_pkg::V_RES,
  parameter int unsigned ADDR_W = pixel_write_ctrl_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [WIDTH-1:0]  pix_x,
  input  logic [WIDTH-1:0]  pix_y,
  input  logic              steep,
  input  logic [7:0]        pix_color,
  input  logic              pix_last,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  input  logic              fb_ack,
  output logic              line_finished,
  output logic [WIDTH-1:0]  drop_cnt
);
  import pixel_write_ctrl_pkg::*;

  localparam int unsigned DW = ADDR_W + COLOR_W + 2;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   x, y;
  logic [ADDR_W-1:0]  addr_c;
  logic               out_of_range, clip;
  logic               push, pop, full, empty, more;
  logic [CW-1:0]      count;
  logic [DW-1:0]      wdata, rdata;
  logic [ADDR_W-1:0]  head_addr;
  logic [COLOR_W-1:0] head_color;
  logic               head_last, head_we;

  state_t             state_q, state_d;
  logic               we_d, lf_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [7:0]         data_d;

  // Undo the octant swap, then form the linear framebuffer address.
  assign x      = steep ? pix_y : pix_x;
  assign y      = steep ? pix_x : pix_y;
  assign addr_c = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);

  assign out_of_range = x[WIDTH-1] | y[WIDTH-1] |
                        (32'(x) >= H_RES) | (32'(y) >= V_RES);

`ifdef PIX_CLIP_EN
  logic [WIDTH-1:0] drop_q;

  assign clip = out_of_range;

  // Saturating count of pixels that were clipped at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                drop_q <= '0;
    else if (push && clip && (drop_q != '1)) drop_q <= drop_q + WIDTH'(1);
  end

  assign drop_cnt = drop_q;
`else
  logic unused_range;

  assign unused_range = out_of_range;
  assign clip         = 1'b0;
  assign drop_cnt     = '0;
`endif

  assign pix_ready = ~full;
  assign push      = pix_valid & ~full;
  assign wdata     = {addr_c, pix_color, pix_last, ~clip};
  assign {head_addr, head_color, head_last, head_we} = rdata;
  assign more      = (count > CW'(1)) | push;

  pix_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Next state: load head into the write port, pop on ack or on a clipped entry.
  always_comb begin
    state_d = state_q;
    we_d    = fb_we;
    addr_d  = fb_addr;
    data_d  = fb_data;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = WRITE;
      end
      WRITE: begin
        if (fb_we) begin
          if (fb_ack) begin
            pop     = 1'b1;
            we_d    = 1'b0;
            state_d = head_last ? DONE : (more ? WRITE : IDLE);
          end
        end else if (empty) begin
          state_d = IDLE;
        end else if (head_we) begin
          we_d   = 1'b1;
          addr_d = head_addr;
          data_d = head_color;
        end else begin
          pop     = 1'b1;
          state_d = head_last ? DONE : (more ? WRITE : IDLE);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    lf_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_data       <= '0;
      line_finished <= 1'b0;
    end else begin
      state_q       <= state_d;
      fb_we         <= we_d;
      fb_addr       <= addr_d;
      fb_data       <= data_d;
      line_finished <= lf_d;
    end
  end

endmodule

// File: tb/tb_pixel_write_ctrl.sv
// Directed self-checking bench for pixel_write_ctrl (honours PIX_CLIP_EN).
module tb_pixel_write_ctrl;

  localparam int unsigned WIDTH  = 10;
  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid;
  logic              pix_ready;
  logic [WIDTH-1:0]  pix_x, pix_y;
  logic              steep;
  logic [7:0]        pix_color;
  logic              pix_last;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              fb_ack;
  logic              line_finished;
  logic [WIDTH-1:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pixel_write_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .steep         (steep),
    .pix_color     (pix_color),
    .pix_last      (pix_last),
    .fb_we         (fb_we),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_ack        (fb_ack),
    .line_finished (line_finished),
    .drop_cnt      (drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic st, input logic [7:0] c, input logic last);
    pix_x     = x;
    pix_y     = y;
    steep     = st;
    pix_color = c;
    pix_last  = last;
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_we(input string tag, input int max_cyc);
    int n = 0;
    while (fb_we !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, 32'(fb_we), 32'(1));
  endtask

  task automatic run_mon(input int cycles, output int nwe, output int nlf,
                         output int w_cyc, output int lf_cyc,
                         output logic [31:0] a0, output logic [31:0] a1);
    nwe = 0; nlf = 0; w_cyc = -1; lf_cyc = -1; a0 = '0; a1 = '0;
    for (int c = 0; c < cycles; c++) begin
      if (fb_we === 1'b1 && fb_ack === 1'b1) begin
        if (nwe == 0)      a0 = 32'(fb_addr);
        else if (nwe == 1) a1 = 32'(fb_addr);
        nwe++;
        w_cyc = c;
      end
      if (line_finished === 1'b1) begin
        if (nlf == 0) lf_cyc = c;
        nlf++;
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          nwe, nlf, w_cyc, lf_cyc, n;
    logic [31:0] a0, a1;
    logic [31:0] got [5];
    logic        acc;

    rst = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; steep = 1'b0;
    pix_color = '0; pix_last = 1'b0; fb_ack = 1'b1;

    // Reset state
    step(); step();
    chk("rst_we",    32'(fb_we), 0);
    chk("rst_addr",  32'(fb_addr), 0);
    chk("rst_data",  32'(fb_data), 0);
    chk("rst_lf",    32'(line_finished), 0);
    chk("rst_drop",  32'(drop_cnt), 0);
    rst = 1'b1;
    step();
    chk("rst_ready", 32'(pix_ready), 1);

    // Pixel (3,5): 5*320+3 = 1603, two cycles after acceptance
    send(10'd3, 10'd5, 1'b0, 8'hAA, 1'b0);
    chk("lat_c0_we", 32'(fb_we), 0);
    step();
    chk("lat_c1_we", 32'(fb_we), 0);
    step();
    chk("lat_c2_we",  32'(fb_we), 1);
    chk("lat_c2_addr", 32'(fb_addr), 1603);
    chk("lat_c2_data", 32'(fb_data), 32'h0AA);
    step();
    chk("single_we", 32'(fb_we), 0);
    step(); step();

    // Steep pixel: (7,2) swapped -> X=2, Y=7 -> 2242
    send(10'd7, 10'd2, 1'b1, 8'h3C, 1'b0);
    step(); step();
    chk("steep_we",   32'(fb_we), 1);
    chk("steep_addr", 32'(fb_addr), 2242);
    step(); step(); step();

    // Backpressure: ack low, 5 pixels offered, only 4 fit
    fb_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pix_x = WIDTH'(k + 1); pix_y = 10'd10; steep = 1'b0;
      pix_color = 8'(16 + k); pix_valid = 1'b1;
      step();
    end
    pix_x = 10'd5; pix_y = 10'd10; pix_color = 8'h14;
    chk("full_ready", 32'(pix_ready), 0);
    step(); step();
    chk("held_ready", 32'(pix_ready), 0);
    chk("held_we",    32'(fb_we), 1);
    chk("held_addr",  32'(fb_addr), 3201);
    chk("held_data",  32'(fb_data), 32'h10);
    fb_ack = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (fb_we === 1'b1) begin
        got[n] = 32'(fb_addr);
        n++;
      end
      acc = pix_valid & pix_ready;
      step();
      if (acc) pix_valid = 1'b0;
    end
    pix_valid = 1'b0;
    chk("bp_write_count", 32'(n), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("bp_order_%0d", k), got[k], 32'(3201 + k));
    step(); step();

    // Three-pixel line, last on the third
    send(10'd0,   10'd0,   1'b0, 8'h01, 1'b0);
    send(10'd1,   10'd0,   1'b0, 8'h02, 1'b0);
    send(10'd319, 10'd239, 1'b0, 8'h03, 1'b1);
    run_mon(14, nwe, nlf, w_cyc, lf_cyc, a0, a1);
    chk("line_writes",  32'(nwe), 3);
    chk("line_first",   a0, 0);
    chk("line_second",  a1, 1);
    chk("line_lf_once", 32'(nlf), 1);
    chk("line_lf_delay", 32'(lf_cyc - w_cyc), 1);

`ifdef PIX_CLIP_EN
    // Clipped pixels: (320,0) and (-1,4), last on the second
    send(10'd320,  10'd0, 1'b0, 8'h11, 1'b0);
    send(10'h3FF,  10'd4, 1'b0, 8'h22, 1'b1);
    run_mon(12, nwe, nlf, w_cyc, lf_cyc, a0, a1);
    chk("clip_no_we",  32'(nwe), 0);
    chk("clip_lf",     32'(nlf), 1);
    chk("clip_drop",   32'(drop_cnt), 2);
`else
    // Without clipping, raw addresses 320 and 4*320+1023 = 2303
    send(10'd320,  10'd0, 1'b0, 8'h11, 1'b0);
    send(10'h3FF,  10'd4, 1'b0, 8'h22, 1'b1);
    run_mon(12, nwe, nlf, w_cyc, lf_cyc, a0, a1);
    chk("raw_writes", 32'(nwe), 2);
    chk("raw_addr0",  a0, 320);
    chk("raw_addr1",  a1, 2303);
    chk("raw_lf",     32'(nlf), 1);
    chk("raw_drop",   32'(drop_cnt), 0);
`endif

    // Reset while a write is outstanding
    fb_ack = 1'b0;
    send(10'd9, 10'd9, 1'b0, 8'h77, 1'b1);
    wait_we("mid_pre_we", 10);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_we",    32'(fb_we), 0);
    chk("mid_rst_addr",  32'(fb_addr), 0);
    chk("mid_rst_lf",    32'(line_finished), 0);
    chk("mid_rst_ready", 32'(pix_ready), 1);
    step(); step();
    rst = 1'b1;
    fb_ack = 1'b1;
    run_mon(8, nwe, nlf, w_cyc, lf_cyc, a0, a1);
    chk("post_rst_no_we", 32'(nwe), 0);
    chk("post_rst_no_lf", 32'(nlf), 0);
    send(10'd4, 10'd0, 1'b0, 8'h55, 1'b0);
    wait_we("post_rst_we", 6);
    chk("post_rst_addr", 32'(fb_addr), 4);
    chk("post_rst_data", 32'(fb_data), 32'h55);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
